// File: rtl/sr_drive_sequencer_if.sv
// Request handshake between a write requester and sr_drive_sequencer.
// The master presents a target bit; the slave signals when it can accept one.
interface sr_drive_sequencer_if;
    logic req_valid;
    logic req_bit;
    logic req_ready;

    modport master (output req_valid, output req_bit, input req_ready);
    modport slave  (input req_valid, input req_bit, output req_ready);
endinterface

// File: rtl/sr_drive_sequencer.sv
// Writes one bit into an external SR flip-flop through its S/R inputs and
// confirms the write by watching q/qb feedback, reporting done or timeout.
module sr_drive_sequencer #(
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned TIMEOUT  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    sr_drive_sequencer_if.slave        req,
    output logic                       s,
    output logic                       r,
    input  logic                       q_fb,
    input  logic                       qb_fb,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [7:0]                 err_cnt,
    output logic [7:0]                 xfer_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

    localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TMO_LD  = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       tgt_q, tgt_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] xfer_cnt_q, xfer_cnt_d;
    logic       fb_match;

    // Unknown or equal feedback never satisfies both terms, so it reads as a miss.
    assign fb_match = (q_fb == tgt_q) && (qb_fb == ~tgt_q);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        s_d        = s_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            IDLE: begin
                if (req.req_valid && ready_q) begin
                    state_d = DRIVE;
                    tgt_d   = req.req_bit;
                    s_d     = req.req_bit;
                    r_d     = ~req.req_bit;
                    cnt_d   = HOLD_LD;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                    cnt_d   = TMO_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (fb_match) begin
                    state_d    = RESP;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 8'd1;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered ready lets the cycle right after a reset edge stay closed.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign req.req_ready = ready_q;
    assign s             = s_q;
    assign r             = r_q;
    assign busy          = (state_q == DRIVE) || (state_q == CHECK);
    assign done          = done_q;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Self-checking bench for sr_drive_sequencer: a cycle-offset transaction model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_sr_drive_sequencer;

    localparam int unsigned HOLD = 1;
    localparam int unsigned TMO  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s, r, busy, done, err;
    logic [7:0] err_cnt, xfer_cnt;
    logic       q_fb, qb_fb;
    logic [1:0] fb_mode = 2'd0;  // 0 ideal flop, 1 stuck q=0, 2 both high, 3 unknown
    logic       iq = 1'b0;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned done_pulses = 0;

    sr_drive_sequencer_if intf ();

    sr_drive_sequencer #(.HOLD_CYC(HOLD), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (intf),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .qb_fb    (qb_fb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    // External SR flop: 10 sets, 01 clears, anything else holds.
    always @(posedge clk) begin
        if (s && !r)      iq <= 1'b1;
        else if (r && !s) iq <= 1'b0;
    end

    assign q_fb  = (fb_mode == 2'd0) ? iq  : (fb_mode == 2'd1) ? 1'b0 : (fb_mode == 2'd2) ? 1'b1 : 1'bx;
    assign qb_fb = (fb_mode == 2'd0) ? ~iq : (fb_mode == 2'd1) ? 1'b1 : (fb_mode == 2'd2) ? 1'b1 : 1'bx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: m_n counts cycles since the accept edge (0 = no write open).
    int unsigned m_n = 0;
    int unsigned m_resp = 0;
    bit          m_tgt = 0, m_ready = 0, m_s = 0, m_r = 1, m_done = 0, m_err = 0;
    int unsigned m_xfer = 0, m_errc = 0;

    task automatic model_edge();
        bit hit;
        hit = (q_fb === m_tgt) && (qb_fb === !m_tgt);
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_n = 0; m_resp = 0; m_ready = 0; m_s = 0; m_r = 1; m_tgt = 0;
            m_xfer = 0; m_errc = 0;
        end else if (m_resp != 0) begin
            m_resp = 0; m_n = 0; m_ready = 1;
        end else if (m_n == 0) begin
            if (m_ready && intf.req_valid) begin
                m_n = 1; m_tgt = intf.req_bit; m_s = intf.req_bit; m_r = !intf.req_bit; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end else if (m_n > HOLD && hit) begin
            m_resp = 1; m_done = 1; m_xfer = (m_xfer + 1) % 256;
        end else if (m_n == HOLD + TMO) begin
            m_resp = 2; m_err = 1; m_errc = (m_errc < 255) ? m_errc + 1 : 255;
        end else begin
            m_n++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("ready",    intf.req_ready, m_ready);
            check("s",        s, m_s);
            check("r",        r, m_r);
            check("busy",     busy, (m_n != 0 && m_resp == 0));
            check("done",     done, m_done);
            check("err",      err, m_err);
            check("err_cnt",  err_cnt, m_errc);
            check("xfer_cnt", xfer_cnt, m_xfer);
            check("sr_legal", s ^ r, 1);
            if (done) done_pulses++;
        end
    end

    task automatic wait_ready();
        int unsigned k = 0;
        while (intf.req_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("wait_ready", intf.req_ready, 1);
    endtask

    // Leaves the caller at the negedge of the first DRIVE cycle.
    task automatic do_write(input bit b);
        wait_ready();
        intf.req_bit   = b;
        intf.req_valid = 1'b1;
        @(negedge clk);
        intf.req_valid = 1'b0;
    endtask

    initial begin
        bit pat [4];
        int unsigned d0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        intf.req_valid = 1'b0;
        intf.req_bit   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", intf.req_ready, 0);
        check("rst_sr", {s, r}, 2'b01);
        check("rst_cnts", {err_cnt, xfer_cnt}, 16'h0000);
        rst = 1'b0;

        // Ideal flop, write 1: code in cycle 1, done in cycle 3.
        do_write(1'b1);
        check("t1_sr_c1", {s, r}, 2'b10);
        @(negedge clk);
        check("t1_done_c2", done, 0);
        @(negedge clk);
        check("t1_done_c3", done, 1);
        check("t1_xfer", xfer_cnt, 1);
        check("t1_qfb", q_fb, 1);

        // Feedback stuck at q=0: err lands in cycle 6.
        wait_ready();
        fb_mode = 2'd1;
        do_write(1'b1);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            check("t2_err_cycle", err, (c == 6));
        end
        check("t2_err_cnt", err_cnt, 1);
        fb_mode = 2'd0;

        // Back-to-back 1,0,1,0 with valid held high.
        wait_ready();
        d0 = done_pulses;
        intf.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            intf.req_bit = pat[i];
            @(negedge clk);
            check("t3_sr", {s, r}, pat[i] ? 2'b10 : 2'b01);
        end
        intf.req_valid = 1'b0;
        wait_ready();
        check("t3_dones", done_pulses - d0, 4);
        check("t3_xfer", xfer_cnt, 5);

        // Both-high and unknown feedback are misses.
        fb_mode = 2'd2;
        do_write(1'b1);
        wait_ready();
        fb_mode = 2'd3;
        do_write(1'b0);
        wait_ready();
        check("t6_err_cnt", err_cnt, 3);
        fb_mode = 2'd0;

        // Reset during CHECK aborts cleanly.
        fb_mode = 2'd1;
        do_write(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_sr", {s, r}, 2'b01);
        check("t4_flags", {busy, done, err, intf.req_ready}, 4'b0000);
        check("t4_cnts", {err_cnt, xfer_cnt}, 16'h0000);
        rst = 1'b0;
        fb_mode = 2'd0;

        // Wrap and saturation.
        for (int i = 0; i < 256; i++) do_write(i[0]);
        wait_ready();
        check("t5_xfer_wrap", xfer_cnt, 0);
        fb_mode = 2'd1;
        for (int i = 0; i < 300; i++) do_write(1'b1);
        wait_ready();
        check("t5_err_sat", err_cnt, 255);
        fb_mode = 2'd0;

        // Random traffic, feedback faults and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            intf.req_valid = 1'($urandom_range(0, 1));
            intf.req_bit   = 1'($urandom_range(0, 1));
            fb_mode        = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            rst            = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        intf.req_valid = 1'b0;
        fb_mode = 2'd0;
        repeat (12) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
